// File: rtl/fpu_dp_pkg.sv
// ---------------------------------------------------------------------------
// fpu_dp_pkg
// Shared constants, state encoding and operand classification for the
// iterative double-precision reciprocal engine (fpu_dp_recip_seq).
//   C1, C2      : linear seed X0 = 48/17 - 32/17 * D for D in [0.5, 1)
//   C3          : 2.0, the Newton-Raphson correction constant
//   RECIP_BIAS_M1 : exponent bias minus one, used when re-biasing the result
//   QNAN, INF   : canonical special results
// Optional feature macro: FPU_RECIP_SPECIAL_EN (consumers use classify()).
// ---------------------------------------------------------------------------
package fpu_dp_pkg;

    localparam logic [63:0] C1            = 64'h4006969696969697;
    localparam logic [63:0] C2            = 64'h3FFE1E1E1E1E1E1E;
    localparam logic [63:0] C3            = 64'h4000000000000000;
    localparam logic [10:0] RECIP_BIAS_M1 = 11'd1022;
    localparam logic [63:0] QNAN          = 64'h7FF8000000000000;
    localparam logic [63:0] INF           = 64'h7FF0000000000000;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEED_MUL = 3'd1,
        SEED_ADD = 3'd2,
        IT_MUL1  = 3'd3,
        IT_ADD   = 3'd4,
        IT_MUL2  = 3'd5,
        FIX      = 3'd6,
        DONE     = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        SPC_NONE = 2'd0,
        SPC_INF  = 2'd1,
        SPC_ZERO = 2'd2,
        SPC_NAN  = 2'd3
    } spc_t;

    // Zero/denormal operands give infinity, inf gives zero, NaN gives qNaN.
    function automatic spc_t classify(input logic [10:0] e, input logic mant_nz);
        spc_t c;
        if (e == 11'd0) begin
            c = SPC_INF;
        end else if (e == 11'h7FF) begin
            c = mant_nz ? SPC_NAN : SPC_ZERO;
        end else begin
            c = SPC_NONE;
        end
        return c;
    endfunction

endpackage

// File: rtl/fpu_dp_adder.sv
// ---------------------------------------------------------------------------
// fpu_dp_adder
// Combinational IEEE-754 double add, round-to-nearest-even, normal operands.
//   a, b : operands
//   y    : sum
//   flag : exponent overflow or underflow of a nonzero result
// ---------------------------------------------------------------------------
module fpu_dp_adder (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] y,
    output logic        flag
);

    logic        swap_s;
    logic [63:0] big_s;
    logic [63:0] sml_s;
    logic [10:0] eb_s;
    logic [10:0] es_s;
    logic [10:0] d_s;
    logic [56:0] mb_s;
    logic [56:0] ms_s;
    logic [56:0] sh_s;
    logic [56:0] sum_s;
    logic [56:0] norm_s;
    logic        sub_s;
    logic [5:0]  lead_s;
    logic [5:0]  shl_s;
    logic [12:0] exv_s;
    logic [51:0] mant_s;
    logic        rnd_s;
    logic        unf_s;
    logic        ovf_s;
    logic [62:0] mag_s;

    // Align, add/subtract, renormalise and round.
    always_comb begin
        swap_s = (b[62:0] > a[62:0]);
        big_s  = swap_s ? b : a;
        sml_s  = swap_s ? a : b;
        eb_s   = big_s[62:52];
        es_s   = sml_s[62:52];
        // Layout: [56] carry, [55] hidden, [54:3] fraction, [2:0] guard/round/sticky.
        mb_s   = {1'b0, (eb_s != 11'd0), big_s[51:0], 3'b000};
        ms_s   = {1'b0, (es_s != 11'd0), sml_s[51:0], 3'b000};
        d_s    = eb_s - es_s;
        if (d_s > 11'd56) begin
            sh_s = {56'd0, (ms_s != 57'd0)};
        end else begin
            sh_s = (ms_s >> d_s) | {56'd0, ((ms_s & ((57'd1 << d_s) - 57'd1)) != 57'd0)};
        end
        sub_s = big_s[63] ^ sml_s[63];
        sum_s = sub_s ? (mb_s - sh_s) : (mb_s + sh_s);
        lead_s = 6'd0;
        for (int i = 0; i < 57; i++) begin
            lead_s = sum_s[i] ? 6'(i) : lead_s;
        end
        if (lead_s == 6'd56) begin
            shl_s  = 6'd0;
            norm_s = {1'b0, sum_s[56:1]} | {56'd0, sum_s[0]};
            exv_s  = {2'b00, eb_s} + 13'd1;
            unf_s  = 1'b0;
        end else begin
            shl_s  = 6'd55 - lead_s;
            norm_s = sum_s << shl_s;
            exv_s  = {2'b00, eb_s} - {7'd0, shl_s};
            unf_s  = ({2'b00, eb_s} <= {7'd0, shl_s});
        end
        mant_s = norm_s[54:3];
        rnd_s  = norm_s[2] & ((norm_s[1:0] != 2'b00) | mant_s[0]);
        mag_s  = {exv_s[10:0], mant_s} + {62'd0, rnd_s};
        ovf_s  = (exv_s >= 13'd2047);
        flag   = 1'b0;
        // Hidden bit must land at 55; otherwise the operands cancelled to zero.
        if (norm_s[56:55] != 2'b01) begin
            y = 64'd0;
        end else if (unf_s) begin
            y    = {big_s[63], 63'd0};
            flag = 1'b1;
        end else if (ovf_s) begin
            y    = {big_s[63], 11'h7FF, 52'd0};
            flag = 1'b1;
        end else begin
            y = {big_s[63], mag_s};
        end
    end

endmodule

// File: rtl/fpu_dp_multiplier.sv
// ---------------------------------------------------------------------------
// fpu_dp_multiplier
// Combinational IEEE-754 double multiply, round-to-nearest-even.
// Normal operands only; a zero/denormal exponent is treated as zero,
// results below the normal range flush to zero, above it saturate to inf.
//   a, b : operands
//   y    : product
// ---------------------------------------------------------------------------
module fpu_dp_multiplier (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] y
);

    logic [52:0]  ma_s;
    logic [52:0]  mb_s;
    logic [105:0] prod_s;
    logic         norm_s;
    logic [51:0]  mant_s;
    logic         guard_s;
    logic         sticky_s;
    logic         rnd_s;
    logic [12:0]  ev_s;
    logic [10:0]  e11_s;
    logic [62:0]  mag_s;
    logic         sign_s;

    // Full-width significand product, normalisation and rounding.
    always_comb begin
        sign_s = a[63] ^ b[63];
        ma_s   = {1'b1, a[51:0]};
        mb_s   = {1'b1, b[51:0]};
        prod_s = {53'd0, ma_s} * {53'd0, mb_s};
        norm_s = prod_s[105];
        if (norm_s) begin
            mant_s   = prod_s[104:53];
            guard_s  = prod_s[52];
            sticky_s = (prod_s[51:0] != 52'd0);
        end else begin
            mant_s   = prod_s[103:52];
            guard_s  = prod_s[51];
            sticky_s = (prod_s[50:0] != 51'd0);
        end
        rnd_s = guard_s & (sticky_s | mant_s[0]);
        // Biased exponent sum kept wide so range checks see true magnitude.
        ev_s  = {2'b00, a[62:52]} + {2'b00, b[62:52]} + {12'd0, norm_s};
        e11_s = a[62:52] + b[62:52] + {10'd0, norm_s} - 11'd1023;
        mag_s = {e11_s, mant_s} + {62'd0, rnd_s};
        if ((a[62:52] == 11'd0) || (b[62:52] == 11'd0) || (ev_s <= 13'd1023)) begin
            y = {sign_s, 63'd0};
        end else if (ev_s >= 13'd3070) begin
            y = {sign_s, 11'h7FF, 52'd0};
        end else begin
            y = {sign_s, mag_s};
        end
    end

endmodule

// File: rtl/fpu_dp_recip_exp_fix.sv
// ---------------------------------------------------------------------------
// fpu_dp_recip_exp_fix
// Combinational result packer: rebiases the reciprocal of the normalised
// significand D in [0.5, 1) back to the operand's exponent, restores sign.
//   x_mag : magnitude bits of the converged X = 1/D
//   s, e  : captured operand sign and biased exponent
//   spc   : operand class (only with FPU_RECIP_SPECIAL_EN)
//   res   : packed double result
// With FPU_RECIP_SPECIAL_EN defined, special operand classes override res.
// ---------------------------------------------------------------------------
module fpu_dp_recip_exp_fix
    import fpu_dp_pkg::*;
(
    input  logic [62:0] x_mag,
    input  logic        s,
    input  logic [10:0] e,
`ifdef FPU_RECIP_SPECIAL_EN
    input  spc_t        spc,
`endif
    output logic [63:0] res
);

    // 1/b = 1/D * 2^(1022-e+1023-1023); exponent wraps modulo 2^11 by design.
    always_comb begin
        res = {s, (x_mag[62:52] + RECIP_BIAS_M1 - e), x_mag[51:0]};
`ifdef FPU_RECIP_SPECIAL_EN
        case (spc)
            SPC_INF:  res = {s, INF[62:0]};
            SPC_ZERO: res = {s, 63'd0};
            SPC_NAN:  res = QNAN;
            default:  res = {s, (x_mag[62:52] + RECIP_BIAS_M1 - e), x_mag[51:0]};
        endcase
`endif
    end

endmodule

// File: rtl/fpu_dp_recip_seq.sv
// ---------------------------------------------------------------------------
// fpu_dp_recip_seq
// Iterative double-precision reciprocal: one shared multiplier and one shared
// adder walk a Newton-Raphson schedule, one operation per cycle.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake, in_data = IEEE double b
//   out_valid/out_ready  : result handshake, out_data = recip(b)
//   busy                 : engine not idle
// Optional feature macro: FPU_RECIP_SPECIAL_EN (zero/inf/NaN short-cut).
// ---------------------------------------------------------------------------
module fpu_dp_recip_seq #(
    parameter int WIDTH = 64,
    parameter int ITERS = 6,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);
    import fpu_dp_pkg::*;

    localparam logic [CNT_W-1:0] ITERS_C = CNT_W'(ITERS);

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [63:0]      x_r;
    logic [63:0]      t_r;
    logic [51:0]      dm_r;
    logic             s_r;
    logic [10:0]      e_r;
    logic [63:0]      out_data_r;
    logic             out_valid_r;
    logic             in_ready_r;
    logic             busy_r;
    logic             accept_s;
    logic [63:0]      d_s;
    logic [63:0]      mul_a_s;
    logic [63:0]      mul_b_s;
    logic [63:0]      mul_y_s;
    logic [63:0]      add_a_s;
    logic [63:0]      add_b_s;
    logic [63:0]      add_y_s;
    logic             add_flag_unused;
    logic [63:0]      fix_s;
`ifdef FPU_RECIP_SPECIAL_EN
    spc_t             spc_r;
`endif

    assign accept_s  = in_valid & in_ready_r;
    assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    assign d_s       = {1'b0, RECIP_BIAS_M1, dm_r};

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;

    fpu_dp_multiplier u_mul (
        .a (mul_a_s),
        .b (mul_b_s),
        .y (mul_y_s)
    );

    fpu_dp_adder u_add (
        .a    (add_a_s),
        .b    (add_b_s),
        .y    (add_y_s),
        .flag (add_flag_unused)
    );

    fpu_dp_recip_exp_fix u_fix (
        .x_mag (x_r[62:0]),
        .s     (s_r),
        .e     (e_r),
`ifdef FPU_RECIP_SPECIAL_EN
        .spc   (spc_r),
`endif
        .res   (fix_s)
    );

    // Shared-unit operand muxes; subtraction is done by flipping T's sign.
    always_comb begin
        mul_a_s = 64'd0;
        mul_b_s = 64'd0;
        add_a_s = 64'd0;
        add_b_s = 64'd0;
        case (state_r)
            SEED_MUL: begin
                mul_a_s = C2;
                mul_b_s = d_s;
            end
            SEED_ADD: begin
                add_a_s = C1;
                add_b_s = {~t_r[63], t_r[62:0]};
            end
            IT_MUL1: begin
                mul_a_s = d_s;
                mul_b_s = x_r;
            end
            IT_ADD: begin
                add_a_s = C3;
                add_b_s = {~t_r[63], t_r[62:0]};
            end
            IT_MUL2: begin
                mul_a_s = x_r;
                mul_b_s = t_r;
            end
            default: begin
                mul_a_s = 64'd0;
                mul_b_s = 64'd0;
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:     state_s = accept_s ? SEED_MUL : IDLE;
`ifdef FPU_RECIP_SPECIAL_EN
            // Special operands pass through SEED_MUL once, then pack the preselected result.
            SEED_MUL: state_s = (spc_r != SPC_NONE) ? FIX : SEED_ADD;
`else
            SEED_MUL: state_s = SEED_ADD;
`endif
            SEED_ADD: state_s = IT_MUL1;
            IT_MUL1:  state_s = IT_ADD;
            IT_ADD:   state_s = IT_MUL2;
            IT_MUL2:  state_s = (cnt_inc_s < ITERS_C) ? IT_MUL1 : FIX;
            FIX:      state_s = DONE;
            DONE:     state_s = (out_valid_r && out_ready) ? IDLE : DONE;
            default:  state_s = IDLE;
        endcase
    end

    // State register plus status flags derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s == IDLE);
            busy_r     <= (state_s != IDLE);
        end
    end

    // Datapath registers: each state commits exactly one unit result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= {CNT_W{1'b0}};
            x_r         <= 64'd0;
            t_r         <= 64'd0;
            dm_r        <= 52'd0;
            s_r         <= 1'b0;
            e_r         <= 11'd0;
            out_data_r  <= 64'd0;
            out_valid_r <= 1'b0;
`ifdef FPU_RECIP_SPECIAL_EN
            spc_r       <= SPC_NONE;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        s_r  <= in_data[63];
                        e_r  <= in_data[62:52];
                        dm_r <= in_data[51:0];
`ifdef FPU_RECIP_SPECIAL_EN
                        spc_r <= classify(in_data[62:52], (in_data[51:0] != 52'd0));
`endif
                    end
                end
                SEED_MUL: t_r <= mul_y_s;
                SEED_ADD: begin
                    x_r   <= add_y_s;
                    cnt_r <= {CNT_W{1'b0}};
                end
                IT_MUL1:  t_r <= mul_y_s;
                IT_ADD:   t_r <= add_y_s;
                IT_MUL2: begin
                    x_r   <= mul_y_s;
                    cnt_r <= cnt_inc_s;
                end
                FIX: begin
                    out_data_r  <= fix_s;
                    out_valid_r <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_dp_recip_seq.sv
// ---------------------------------------------------------------------------
// tb_fpu_dp_recip_seq
// Scoreboard bench for fpu_dp_recip_seq: the driver pushes hand-computed
// expected results, a negedge monitor pops and compares on each output
// handshake and checks latency and output hold. Iterated results are
// accepted within 1 ulp of the exact reciprocal.
// ---------------------------------------------------------------------------
module tb_fpu_dp_recip_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        busy;

    typedef struct {
        logic [63:0] data;
        logic [63:0] tol;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_hs = -100;
    int   last_acc = 0;

    fpu_dp_recip_seq #(.WIDTH(64), .ITERS(6), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] absdiff(input logic [63:0] x, input logic [63:0] y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

    task automatic check1(input string name, input logic act, input logic req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    // Present an operand and wait (bounded) for it to be accepted.
    task automatic send(input logic [63:0] data, input bit push,
                        input logic [63:0] expd, input logic [63:0] tol, input int lat);
        bit ok;
        exp_t e;
        ok = 1'b0;
        in_data  = data;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: operand %h never accepted, required acceptance", data);
        end
        last_acc = cyc + 1;
        if (push && ok) begin
            e.data = expd;
            e.tol  = tol;
            e.acc  = last_acc;
            e.lat  = lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
    endtask

    // Monitor: latency on rise, hold while stalled, data on handshake.
    initial begin : monitor
        logic        pv;
        logic        pr;
        logic [63:0] pd;
        exp_t        e;
        pv = 1'b0;
        pr = 1'b0;
        pd = 64'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                pr = 1'b0;
            end else begin
                if (out_valid && !pv) begin
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_output: got out_valid with %h, required no output", out_data);
                    end else if (cyc - sb[0].acc != sb[0].lat) begin
                        fails++;
                        $display("FAIL latency: got %0d cycles, required %0d", cyc - sb[0].acc, sb[0].lat);
                    end
                end
                if (out_valid && pv && !pr) begin
                    tests++;
                    if (out_data !== pd) begin
                        fails++;
                        $display("FAIL hold: got %h, required %h", out_data, pd);
                    end
                end
                if (out_valid && out_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    tests++;
                    if ($isunknown(out_data) || absdiff(out_data, e.data) > e.tol) begin
                        fails++;
                        $display("FAIL result: got %h, required %h (tol %0d ulp)", out_data, e.data, e.tol);
                    end
                    last_hs = cyc + 1;
                end
                pv = out_valid;
                pr = out_ready;
                pd = out_data;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit seen;
        int acc1;
        logic [63:0] held;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // Reset state.
        check1("reset_in_ready", in_ready, 1'b1);
        check1("reset_out_valid", out_valid, 1'b0);
        check1("reset_busy", busy, 1'b0);
        tests++;
        if (out_data !== 64'd0) begin
            fails++;
            $display("FAIL reset_out_data: got %h, required 0", out_data);
        end
        @(posedge clk);
        #1;

        // 1.0 and -4.0 with the consumer always ready.
        send(64'h3FF0000000000000, 1'b1, 64'h3FF0000000000000, 64'd1, 21);
        in_valid = 1'b0;
        @(negedge clk);
        check1("busy_running", busy, 1'b1);
        drain();
        @(posedge clk); #1;
        send(64'hC010000000000000, 1'b1, 64'hBFD0000000000000, 64'd1, 21);
        in_valid = 1'b0;
        drain();

        // 1.5 with the consumer stalled for 5 cycles.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(64'h3FF8000000000000, 1'b1, 64'h3FE5555555555555, 64'd1, 21);
        in_valid = 1'b1;
        in_data  = 64'h4000000000000000;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check1("stall_valid_seen", seen, 1'b1);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check1("stall_in_ready", in_ready, 1'b0);
            check1("stall_out_valid", out_valid, 1'b1);
        end
        tests++;
        if (out_data !== held) begin
            fails++;
            $display("FAIL stall_data: got %h, required %h", out_data, held);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Back-to-back 2.0 then 8.0 with in_valid held high.
        @(posedge clk); #1;
        send(64'h4000000000000000, 1'b1, 64'h3FE0000000000000, 64'd1, 21);
        acc1 = last_acc;
        send(64'h4020000000000000, 1'b1, 64'h3FC0000000000000, 64'd1, 21);
        in_valid = 1'b0;
        tests++;
        if (last_acc - last_hs != 1 || last_hs < acc1) begin
            fails++;
            $display("FAIL b2b_accept: got accept %0d after handshake %0d, required 1 cycle later", last_acc, last_hs);
        end
        drain();

        // Reset in the middle of an operation.
        @(posedge clk); #1;
        send(64'h4008000000000000, 1'b0, 64'd0, 64'd0, 21);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check1("abort_no_valid", seen, 1'b0);
        check1("abort_in_ready", in_ready, 1'b1);
        tests++;
        if (out_data !== 64'd0) begin
            fails++;
            $display("FAIL abort_out_data: got %h, required 0", out_data);
        end
        @(posedge clk); #1;
        send(64'h4000000000000000, 1'b1, 64'h3FE0000000000000, 64'd1, 21);
        in_valid = 1'b0;
        drain();

`ifdef FPU_RECIP_SPECIAL_EN
        @(posedge clk); #1;
        send(64'h0000000000000000, 1'b1, 64'h7FF0000000000000, 64'd0, 2);
        in_valid = 1'b0;
        drain();
        @(posedge clk); #1;
        send(64'hFFF0000000000000, 1'b1, 64'h8000000000000000, 64'd0, 2);
        in_valid = 1'b0;
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
